// File: rtl/mult8_sequencer.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 multiplier is time-shared
// over four nibble-pair steps, with shifted partial products accumulated to 16 bits.

module Multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  always_comb begin
    p = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        p = p + (8'(a) << i);
      end
    end
  end

endmodule

module mult8_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic [15:0] acc;
  logic [1:0]  step;
  logic [3:0]  mx;
  logic [3:0]  my;
  logic [7:0]  pp;
  logic [15:0] term;

  // step[0] picks the multiplicand nibble, step[1] the multiplier nibble;
  // the shift is the sum of both nibble weights.
  always_comb begin
    mx = step[0] ? ra[7:4] : ra[3:0];
    my = step[1] ? rb[7:4] : rb[3:0];
    case (step)
      2'd0:    term = {8'h00, pp};
      2'd1,
      2'd2:    term = {4'h0, pp, 4'h0};
      default: term = {pp, 8'h00};
    endcase
  end

  Multiplier_4bit mul_unit (
    .a(mx),
    .b(my),
    .p(pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= 16'h0000;
      acc   <= 16'h0000;
      step  <= 2'd0;
      ra    <= 8'h00;
      rb    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            acc   <= 16'h0000;
            step  <= 2'd0;
            busy  <= 1'b1;
            state <= MUL;
          end else begin
            busy <= 1'b0;
          end
        end
        MUL: begin
          acc  <= acc + term;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            p     <= acc + term;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          step  <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_sequencer.sv
// Randomized self-checking bench for mult8_sequencer; expected products and
// handshake timing come from plain arithmetic and the request edge timeline.

module tb_mult8_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] lastP   = 16'h0000;

  always #5 clk = ~clk;

  mult8_sequencer dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .p    (p)
  );

  // Advance one rising edge and settle away from it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One request: accept at E0, then follow E1..E5 against the timeline.
  // noise keeps start high with junk operands while busy; hold leaves start
  // high after E5 so the next request is accepted at E6.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input bit noise, input bit hold, input string tag);
    logic [15:0] want;
    want  = {8'h00, opA} * {8'h00, opB};
    start = 1'b1;
    a     = opA;
    b     = opB;
    tick();
    for (int k = 0; k <= 5; k++) begin
      checkOutput({tag, "_busy"}, {15'h0, busy}, {15'h0, (k <= 4)});
      checkOutput({tag, "_done"}, {15'h0, done}, {15'h0, (k == 4)});
      checkOutput({tag, "_p"}, p, (k >= 4) ? want : lastP);
      if (k < 5) begin
        start = (k == 4) ? (noise | hold) : noise;
        a     = 8'($urandom);
        b     = 8'($urandom);
        tick();
      end
    end
    lastP = want;
    if (!hold) begin
      start = 1'b0;
      tick();
      checkOutput({tag, "_idle_busy"}, {15'h0, busy}, 16'h0000);
      checkOutput({tag, "_idle_done"}, {15'h0, done}, 16'h0000);
      checkOutput({tag, "_idle_p"}, p, want);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'($urandom);
    b     = 8'($urandom);
    repeat (2) tick();
    checkOutput("rst_busy", {15'h0, busy}, 16'h0000);
    checkOutput("rst_done", {15'h0, done}, 16'h0000);
    checkOutput("rst_p", p, 16'h0000);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("post_rst_busy", {15'h0, busy}, 16'h0000);
    lastP = 16'h0000;

    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, "ffxff");
    applyStimulus(8'h00, 8'hA5, 1'b0, 1'b0, "00xa5");
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, "12x34");
    applyStimulus(8'h80, 8'h02, 1'b0, 1'b0, "80x02");
    checkOutput("corner_12x34_value", {8'h00, 8'h12} * 16'h0034, 16'h03A8);

    applyStimulus(8'h10, 8'h10, 1'b1, 1'b0, "busy_reject");

    // Abort at the step-2 edge (E3): reset wins, no done, p cleared.
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_busy", {15'h0, busy}, 16'h0000);
    checkOutput("abort_done", {15'h0, done}, 16'h0000);
    checkOutput("abort_p", p, 16'h0000);
    rst   = 1'b0;
    lastP = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("abort_no_done", {15'h0, done}, 16'h0000);
      checkOutput("abort_idle_busy", {15'h0, busy}, 16'h0000);
    end
    applyStimulus(8'h07, 8'h09, 1'b0, 1'b0, "after_abort");

    applyStimulus(8'h0F, 8'h11, 1'b0, 1'b1, "b2b_first");
    applyStimulus(8'hC3, 8'h5A, 1'b0, 1'b0, "b2b_second");

    for (int n = 0; n < 1000; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
